ps2_rx_fifo: RTL and testbench

- Parametrised PS/2 device-to-host receiver, successor to the single-byte keyboard receiver.
- Adds full frame checking (start, odd parity, stop), a configurable glitch filter and timeout, a receive FIFO with read handshake, and sticky error/overflow flags.
- Sits between the PS/2 pins (keyboard or mouse) and a bus-attached I/O register block that polls or interrupts on rd_valid.

---
 rtl/ps2_rx_fifo_if.sv | 23 ++
 rtl/ps2_rx_fifo.sv | 205 ++++++++++++++++++++
 tb/tb_ps2_rx_fifo.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_rx_fifo_if.sv
// Read-side bus of the PS/2 receiver: FIFO head, pop handshake and sticky status flags.
interface ps2_rx_fifo_if #(
    parameter int unsigned DEPTH_LOG2 = 3
) ();
    logic [7:0]          rd_data;
    logic                rd_valid;
    logic                rd_en;
    logic [DEPTH_LOG2:0] fifo_level;
    logic                overflow;
    logic                parity_err;
    logic                frame_err;
    logic                clr_err;

    modport master (
        output rd_data, rd_valid, fifo_level, overflow, parity_err, frame_err,
        input  rd_en, clr_err
    );

    modport slave (
        input  rd_data, rd_valid, fifo_level, overflow, parity_err, frame_err,
        output rd_en, clr_err
    );
endinterface

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: clock glitch filter, frame check (start/odd parity/stop),
// inactivity timeout, byte FIFO with pop handshake and sticky error flags.
module ps2_rx_fifo #(
    parameter int unsigned FILT_W     = 4,
    parameter int unsigned TIMEOUT    = 5120,
    parameter int unsigned DEPTH_LOG2 = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic ps2_clk,
    input  logic ps2_data,
    ps2_rx_fifo_if.master rx
);
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned LVL_W = DEPTH_LOG2 + 1;
    localparam logic [FILT_W-1:0] LO_TH = FILT_W'(1 << (FILT_W - 2));
    localparam logic [FILT_W-1:0] HI_TH = FILT_W'((1 << FILT_W) - 1 - (1 << (FILT_W - 2)));
    localparam logic [15:0] TO_V = 16'(TIMEOUT);
    localparam logic [3:0]  LAST_BIT = 4'd11;

    typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;

    logic [1:0]        clk_sync;
    logic [1:0]        data_sync;
    logic [FILT_W-1:0] integ;
    logic              filt;
    logic              filt_prev;
    logic              fall;
    logic              rise;
    logic              fedge;
    logic [15:0]       timer;
    logic              timeout;

    state_t            state;
    logic [3:0]        bitcnt;
    logic [10:0]       sh;

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [LVL_W-1:0]      level;
    logic                  overflow_q;
    logic                  parity_err_q;
    logic                  frame_err_q;

    logic stop_ok;
    logic par_ok;
    logic frame_good;
    logic not_empty;
    logic full;
    logic pop;
    logic push;
    logic ovf_set;
    logic pe_set;
    logic fe_set;

    // Two-flop synchronisers on the asynchronous pins; intentionally not reset.
    always_ff @(posedge clk) begin
        clk_sync  <= {clk_sync[0], ps2_clk};
        data_sync <= {data_sync[0], ps2_data};
    end

    // Saturating integrator with hysteresis thresholds rejects short clock glitches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            integ     <= '1;
            filt      <= 1'b1;
            filt_prev <= 1'b1;
        end else begin
            if (clk_sync[1] && integ != '1)
                integ <= integ + FILT_W'(1);
            else if (!clk_sync[1] && integ != '0)
                integ <= integ - FILT_W'(1);

            if (integ == LO_TH)
                filt <= 1'b0;
            else if (integ == HI_TH)
                filt <= 1'b1;

            filt_prev <= filt;
        end
    end

    assign fall  = filt_prev & ~filt;
    assign rise  = ~filt_prev & filt;
    assign fedge = fall | rise;

    // Timeout fires only on the increment that lands on TIMEOUT, so it pulses once.
    assign timeout = !fedge && (timer == TO_V - 16'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            timer <= 16'd0;
        else if (fedge)
            timer <= 16'd0;
        else if (timer != TO_V)
            timer <= timer + 16'd1;
    end

    // sh[0]=start, sh[8:1]=data, sh[9]=parity, sh[10]=stop once the frame is complete.
    assign stop_ok    = sh[10] && !sh[0];
    assign par_ok     = ^sh[9:1];
    assign frame_good = (state == CHECK) && stop_ok && par_ok;

    assign not_empty = (level != '0);
    assign full      = (level == LVL_W'(DEPTH));
    assign pop       = rx.rd_en && not_empty;
    assign push      = frame_good && (!full || pop);
    assign ovf_set   = frame_good && full && !pop;
    assign pe_set    = (state == CHECK) && stop_ok && !par_ok;
    assign fe_set    = ((state == IDLE) && fall && data_sync[1]) ||
                       ((state == RECV) && timeout) ||
                       ((state == CHECK) && !stop_ok);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            bitcnt <= 4'd0;
            sh     <= 11'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (fall && !data_sync[1]) begin
                        sh     <= {data_sync[1], sh[10:1]};
                        bitcnt <= 4'd1;
                        state  <= RECV;
                    end
                end
                RECV: begin
                    if (timeout) begin
                        bitcnt <= 4'd0;
                        state  <= IDLE;
                    end else if (fall) begin
                        sh     <= {data_sync[1], sh[10:1]};
                        bitcnt <= bitcnt + 4'd1;
                        if (bitcnt + 4'd1 == LAST_BIT)
                            state <= CHECK;
                    end
                end
                CHECK: begin
                    bitcnt <= 4'd0;
                    state  <= IDLE;
                end
                default: begin
                    bitcnt <= 4'd0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    // Storage holds no reset; validity is tracked solely by the level counter.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= sh[8:1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            if (pop)
                rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
            if (push && !pop)
                level <= level + LVL_W'(1);
            else if (pop && !push)
                level <= level - LVL_W'(1);
        end
    end

    // Sticky flags: a set in the same cycle as clr_err wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            if (ovf_set)
                overflow_q <= 1'b1;
            else if (rx.clr_err)
                overflow_q <= 1'b0;

            if (pe_set)
                parity_err_q <= 1'b1;
            else if (rx.clr_err)
                parity_err_q <= 1'b0;

            if (fe_set)
                frame_err_q <= 1'b1;
            else if (rx.clr_err)
                frame_err_q <= 1'b0;
        end
    end

    assign rx.rd_data    = not_empty ? mem[rd_ptr] : 8'h00;
    assign rx.rd_valid   = not_empty;
    assign rx.fifo_level = level;
    assign rx.overflow   = overflow_q;
    assign rx.parity_err = parity_err_q;
    assign rx.frame_err  = frame_err_q;
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: table of whole frames plus hand-timed corner sequences.
module tb_ps2_rx_fifo;
    localparam int unsigned DL2 = 3;
    localparam int unsigned TO  = 5120;

    logic clk = 1'b0;
    logic rst;
    logic ps2_clk;
    logic ps2_data;

    int n_cmp = 0;
    int n_bad = 0;

    always #10 clk = ~clk;

    ps2_rx_fifo_if #(.DEPTH_LOG2(DL2)) bus ();

    ps2_rx_fifo #(
        .FILT_W(4),
        .TIMEOUT(TO),
        .DEPTH_LOG2(DL2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ps2_clk(ps2_clk),
        .ps2_data(ps2_data),
        .rx(bus)
    );

    typedef struct {
        logic [7:0] data;
        logic       bad_par;
        logic       stop;
        logic [3:0] exp_level;
        logic [7:0] exp_head;
        logic       exp_pe;
        logic       exp_fe;
        logic       exp_ov;
        logic       pop;
        logic       clr;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic bad_par,
                                             input logic stop);
        return {stop, (~^d) ^ bad_par, d, 1'b0};
    endfunction

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One bit: data set while clock high, 40 cycles low, 20 cycles high.
    task automatic send_bit(input logic b, input logic glitch);
        ps2_data = b;
        if (glitch) begin
            wait_n(5);
            ps2_clk = 1'b0;
            #2;
            ps2_clk = 1'b1;
            wait_n(5);
            ps2_clk = 1'b0;
            wait_n(3);
            ps2_clk = 1'b1;
            wait_n(7);
        end else begin
            wait_n(20);
        end
        ps2_clk = 1'b0;
        wait_n(40);
        ps2_clk = 1'b1;
        wait_n(20);
    endtask

    task automatic send_frame(input logic [10:0] f, input int nbits, input logic glitch);
        for (int i = 0; i < nbits; i++)
            send_bit(f[i], glitch);
    endtask

    // Sends bits 0..9, then drops the pin clock for the stop bit and returns at that edge.
    task automatic frame_to_stop_fall(input logic [10:0] f);
        send_frame(f, 10, 1'b0);
        ps2_data = f[10];
        wait_n(20);
        ps2_clk = 1'b0;
    endtask

    task automatic finish_stop();
        wait_n(40);
        ps2_clk = 1'b1;
        wait_n(20);
    endtask

    task automatic pulse_rd();
        bus.rd_en = 1'b1;
        wait_n(1);
        bus.rd_en = 1'b0;
    endtask

    task automatic pulse_clr();
        bus.clr_err = 1'b1;
        wait_n(1);
        bus.clr_err = 1'b0;
    endtask

    task automatic chk_flags(input string nm, input logic pe, input logic fe, input logic ov);
        chk({nm, "_pe"}, 32'(bus.parity_err), 32'(pe));
        chk({nm, "_fe"}, 32'(bus.frame_err), 32'(fe));
        chk({nm, "_ov"}, 32'(bus.overflow), 32'(ov));
    endtask

    initial begin
        logic [10:0] f;

        //            data   bp    stop  lvl   head   pe    fe    ov    pop   clr
        vecs[0] = '{8'h1C, 1'b0, 1'b1, 4'd1, 8'h1C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{8'h1C, 1'b1, 1'b1, 4'd0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{8'hF0, 1'b0, 1'b1, 4'd1, 8'hF0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{8'h33, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{8'hE7, 1'b1, 1'b0, 4'd0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{8'h00, 1'b0, 1'b1, 4'd1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{8'hFF, 1'b0, 1'b1, 4'd1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{8'h81, 1'b0, 1'b1, 4'd2, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[8] = '{8'h42, 1'b0, 1'b1, 4'd2, 8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[9] = '{8'h7E, 1'b0, 1'b1, 4'd2, 8'h42, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

        rst         = 1'b1;
        ps2_clk     = 1'b1;
        ps2_data    = 1'b1;
        bus.rd_en   = 1'b0;
        bus.clr_err = 1'b0;
        wait_n(3);
        chk("rst_valid", 32'(bus.rd_valid), 32'd0);
        chk("rst_level", 32'(bus.fifo_level), 32'd0);
        chk("rst_data", 32'(bus.rd_data), 32'd0);
        chk_flags("rst", 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        wait_n(20);

        // Latency: pin fall -> 2 sync + 11 integrator + 1 filter = strobe, then CHECK, then push.
        f = mk_frame(8'h1C, 1'b0, 1'b1);
        frame_to_stop_fall(f);
        repeat (15) @(posedge clk);
        #1 chk("lat_before", 32'(bus.rd_valid), 32'd0);
        @(posedge clk);
        #1 chk("lat_valid", 32'(bus.rd_valid), 32'd1);
        chk("lat_data", 32'(bus.rd_data), 32'h1C);
        chk("lat_level", 32'(bus.fifo_level), 32'd1);
        chk_flags("lat", 1'b0, 1'b0, 1'b0);
        finish_stop();
        pulse_rd();
        chk("lat_pop_valid", 32'(bus.rd_valid), 32'd0);
        chk("lat_pop_level", 32'(bus.fifo_level), 32'd0);

        for (int i = 0; i < 10; i++) begin
            send_frame(mk_frame(vecs[i].data, vecs[i].bad_par, vecs[i].stop), 11, 1'b0);
            wait_n(10);
            chk($sformatf("vec%0d_level", i), 32'(bus.fifo_level), 32'(vecs[i].exp_level));
            if (vecs[i].exp_level != 4'd0)
                chk($sformatf("vec%0d_head", i), 32'(bus.rd_data), 32'(vecs[i].exp_head));
            chk_flags($sformatf("vec%0d", i), vecs[i].exp_pe, vecs[i].exp_fe, vecs[i].exp_ov);
            if (vecs[i].pop) pulse_rd();
            if (vecs[i].clr) pulse_clr();
        end
        pulse_rd();
        chk("drain_level", 32'(bus.fifo_level), 32'd0);
        pulse_rd();
        chk("empty_rd_level", 32'(bus.fifo_level), 32'd0);
        chk("empty_rd_valid", 32'(bus.rd_valid), 32'd0);

        // Timeout: 5 bits then clock held high; filtered rise lands 14 cycles after the pin.
        f = mk_frame(8'h5A, 1'b0, 1'b1);
        send_frame(f, 4, 1'b0);
        ps2_data = f[4];
        wait_n(20);
        ps2_clk = 1'b0;
        wait_n(40);
        ps2_clk = 1'b1;
        repeat (14 + TO) @(posedge clk);
        #1 chk("to_before", 32'(bus.frame_err), 32'd0);
        @(posedge clk);
        #1 chk("to_fire", 32'(bus.frame_err), 32'd1);
        chk("to_level", 32'(bus.fifo_level), 32'd0);
        wait_n(5);
        pulse_clr();
        send_frame(mk_frame(8'h5A, 1'b0, 1'b1), 11, 1'b0);
        wait_n(5);
        chk("to_next_level", 32'(bus.fifo_level), 32'd1);
        chk("to_next_head", 32'(bus.rd_data), 32'h5A);
        chk_flags("to_next", 1'b0, 1'b0, 1'b0);
        pulse_rd();

        // Glitched clock: bad stop is caught, then a clean byte survives the same glitches.
        send_frame(mk_frame(8'h66, 1'b0, 1'b0), 11, 1'b1);
        wait_n(5);
        chk("gl_bad_level", 32'(bus.fifo_level), 32'd0);
        chk_flags("gl_bad", 1'b0, 1'b1, 1'b0);
        pulse_clr();
        send_frame(mk_frame(8'hC3, 1'b0, 1'b1), 11, 1'b1);
        wait_n(5);
        chk("gl_good_level", 32'(bus.fifo_level), 32'd1);
        chk("gl_good_head", 32'(bus.rd_data), 32'hC3);
        chk_flags("gl_good", 1'b0, 1'b0, 1'b0);
        pulse_rd();

        // Overflow: ninth byte dropped.
        for (int i = 1; i <= 9; i++)
            send_frame(mk_frame(8'(i), 1'b0, 1'b1), 11, 1'b0);
        chk("ov_level", 32'(bus.fifo_level), 32'd8);
        chk("ov_flag", 32'(bus.overflow), 32'd1);
        for (int i = 1; i <= 8; i++) begin
            chk($sformatf("ov_read%0d", i), 32'(bus.rd_data), 32'(i));
            pulse_rd();
        end
        chk("ov_drained", 32'(bus.fifo_level), 32'd0);
        pulse_clr();
        chk("ov_cleared", 32'(bus.overflow), 32'd0);

        // Full FIFO: a pop coinciding with the push makes room.
        for (int i = 0; i < 8; i++)
            send_frame(mk_frame(8'h10 + 8'(i), 1'b0, 1'b1), 11, 1'b0);
        chk("pp_full_level", 32'(bus.fifo_level), 32'd8);
        frame_to_stop_fall(mk_frame(8'h18, 1'b0, 1'b1));
        repeat (15) @(posedge clk);
        #1 bus.rd_en = 1'b1;
        @(posedge clk);
        #1 bus.rd_en = 1'b0;
        chk("pp_level", 32'(bus.fifo_level), 32'd8);
        chk("pp_ov", 32'(bus.overflow), 32'd0);
        chk("pp_head", 32'(bus.rd_data), 32'h11);
        finish_stop();
        for (int i = 1; i <= 8; i++) begin
            chk($sformatf("pp_read%0d", i), 32'(bus.rd_data), 32'h10 + 32'(i));
            pulse_rd();
        end

        // Asynchronous reset mid-frame with bytes queued and a flag set.
        send_frame(mk_frame(8'hA1, 1'b0, 1'b1), 11, 1'b0);
        send_frame(mk_frame(8'hA2, 1'b0, 1'b1), 11, 1'b0);
        send_frame(mk_frame(8'hA3, 1'b0, 1'b1), 11, 1'b0);
        send_frame(mk_frame(8'h55, 1'b1, 1'b1), 11, 1'b0);
        chk("mr_pre_level", 32'(bus.fifo_level), 32'd3);
        chk("mr_pre_pe", 32'(bus.parity_err), 32'd1);
        send_frame(mk_frame(8'h99, 1'b0, 1'b1), 4, 1'b0);
        #3 rst = 1'b1;
        #1;
        chk("mr_valid", 32'(bus.rd_valid), 32'd0);
        chk("mr_level", 32'(bus.fifo_level), 32'd0);
        chk("mr_data", 32'(bus.rd_data), 32'd0);
        chk_flags("mr", 1'b0, 1'b0, 1'b0);
        wait_n(3);
        rst      = 1'b0;
        ps2_data = 1'b1;
        wait_n(50);
        send_frame(mk_frame(8'hAA, 1'b0, 1'b1), 11, 1'b0);
        wait_n(5);
        chk("mr_next_level", 32'(bus.fifo_level), 32'd1);
        chk("mr_next_head", 32'(bus.rd_data), 32'hAA);
        chk_flags("mr_next", 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
